// File: rtl/tb_ahb_pkg.sv
// ---------------------------------------------------------------------------
// tb_ahb_pkg
// Shared AHB-Lite encodings and the request record used by the testbench
// AHB-Lite initiator (tb_ahb_master) and its stimulus drivers.
//   HTRANS_*  : transfer type encodings
//   HBURST_*  : burst encodings (only SINGLE is ever issued)
//   HSIZE_*   : transfer size encodings legal for a 32-bit bus
//   ahb_req_t : one request as seen on the valid/ready stream
// ---------------------------------------------------------------------------
package tb_ahb_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [2:0] HBURST_SINGLE = 3'b000;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    typedef struct packed {
        logic        write;
        logic [2:0]  size;
        logic [31:0] address;
        logic [31:0] wdata;
    } ahb_req_t;

endpackage

// File: rtl/tb_ahb_watchdog.sv
// ---------------------------------------------------------------------------
// tb_ahb_watchdog
// Stall watchdog for the AHB-Lite initiator. Counts consecutive cycles in
// which the bus is stalled (hready low) while a transfer is outstanding and
// raises a sticky flag once the count reaches TIMEOUT_CYCLES.
//   clock   : rising-edge clock
//   reset   : asynchronous, active-high
//   hready  : AHB-Lite HREADY; any high cycle clears the count
//   busy    : an address or data phase is outstanding
//   timeout : sticky flag, cleared only by reset
// ---------------------------------------------------------------------------
module tb_ahb_watchdog
    import tb_ahb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic hready,
    input  logic busy,
    output logic timeout
);

    logic [31:0] stall_count;
    logic [31:0] count_next;

    // Saturating count so a permanently hung bus never wraps back below the
    // threshold.
    always_comb begin
        count_next = stall_count;
        if (hready) begin
            count_next = '0;
        end else if (busy && (stall_count != 32'hFFFF_FFFF)) begin
            count_next = stall_count + 32'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stall_count <= '0;
            timeout     <= 1'b0;
        end else begin
            stall_count <= count_next;
            if (count_next >= TIMEOUT_CYCLES) begin
                timeout <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tb_ahb_master.sv
// ---------------------------------------------------------------------------
// tb_ahb_master
// Testbench AHB-Lite initiator. Turns a valid/ready request stream into
// single NONSEQ transfers, keeping at most one address phase (register A)
// and one data phase (register D) in flight, and returns one response pulse
// per request, in request order.
//   clock, reset                     : clock, asynchronous active-high reset
//   req_valid/req_ready              : request handshake
//   req_write/size/address/wdata     : request fields (forwarded unchecked)
//   rsp_valid/rsp_rdata/rsp_error    : one-cycle response per transfer
//   timeout                          : sticky stall watchdog flag
//   htrans..hwdata                   : AHB-Lite master outputs
//   hrdata, hready, hresp            : AHB-Lite responder inputs
// ---------------------------------------------------------------------------
module tb_ahb_master
    import tb_ahb_pkg::*;
#(
    parameter logic [3:0]  HPROT          = 4'b0011,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [2:0]  req_size,
    input  logic [31:0] req_address,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_error,
    output logic        timeout,
    output logic [1:0]  htrans,
    output logic [2:0]  hsize,
    output logic [2:0]  hburst,
    output logic [3:0]  hprot,
    output logic        hmastlock,
    output logic        hwrite,
    output logic [31:0] haddr,
    output logic [31:0] hwdata,
    input  logic [31:0] hrdata,
    input  logic        hready,
    input  logic        hresp
);

    ahb_req_t    req;
    ahb_req_t    a_req;
    logic        a_valid;
    logic        d_valid;
    logic        d_write;
    logic [31:0] d_wdata;
    logic        accept;
    logic        complete;

    assign req = '{write: req_write, size: req_size, address: req_address, wdata: req_wdata};

    // A free address slot is always usable; an occupied one only moves on
    // when the current data phase finishes.
    assign req_ready = !a_valid || hready;
    assign accept    = req_valid && req_ready;
    assign complete  = d_valid && hready;

    // Control state: phase valids and the response pulse.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_valid   <= 1'b0;
            d_valid   <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_error <= 1'b0;
            rsp_rdata <= '0;
        end else begin
            if (hready) begin
                d_valid <= a_valid;
            end
            if (accept) begin
                a_valid <= 1'b1;
            end else if (hready) begin
                a_valid <= 1'b0;
            end
            rsp_valid <= complete;
            // Only the final ERROR cycle is a completion, so an error is
            // reported once and never carries read data.
            rsp_error <= complete && hresp;
            rsp_rdata <= (complete && !d_write && !hresp) ? hrdata : '0;
        end
    end

    // Payload registers: every use is qualified by a_valid/d_valid.
    always_ff @(posedge clock) begin
        if (accept) begin
            a_req <= req;
        end
        if (hready) begin
            d_write <= a_req.write;
            d_wdata <= a_req.wdata;
        end
    end

    // Address phase outputs are forced to zero while idle.
    assign htrans    = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    assign haddr     = a_valid ? a_req.address : '0;
    assign hsize     = a_valid ? a_req.size    : '0;
    assign hwrite    = a_valid && a_req.write;
    assign hwdata    = (d_valid && d_write) ? d_wdata : '0;
    assign hburst    = HBURST_SINGLE;
    assign hmastlock = 1'b0;
    assign hprot     = HPROT;

    tb_ahb_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock  (clock),
        .reset  (reset),
        .hready (hready),
        .busy   (a_valid || d_valid),
        .timeout(timeout)
    );

endmodule

// File: tb/tb_tb_ahb_master.sv
// ---------------------------------------------------------------------------
// tb_tb_ahb_master
// Bench for tb_ahb_master. A behavioural AHB-Lite responder (word memory,
// per-transfer wait states, two-cycle ERROR for 0xFFFFxxxx) sits on the bus;
// a request-order reference model predicts every response.
// ---------------------------------------------------------------------------
module tb_tb_ahb_master;
    import tb_ahb_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid, req_ready, req_write;
    logic [2:0]  req_size;
    logic [31:0] req_address, req_wdata;
    logic        rsp_valid, rsp_error, timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  htrans;
    logic [2:0]  hsize, hburst;
    logic [3:0]  hprot;
    logic        hmastlock, hwrite;
    logic [31:0] haddr, hwdata, hrdata;
    logic        hready, hresp;

    always #5 clock = ~clock;

    tb_ahb_master #(.HPROT(4'b0011), .TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_address(req_address), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
        .timeout(timeout),
        .htrans(htrans), .hsize(hsize), .hburst(hburst), .hprot(hprot),
        .hmastlock(hmastlock), .hwrite(hwrite), .haddr(haddr), .hwdata(hwdata),
        .hrdata(hrdata), .hready(hready), .hresp(hresp)
    );

    typedef struct { ahb_req_t req; int waits; } aphase_t;
    typedef struct { logic [31:0] rdata; logic err; int cyc; int lat; } rsp_t;

    aphase_t     aq[$];
    rsp_t        rq[$];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] slv_mem [logic [31:0]];

    int checks = 0, errors = 0, cyc = 0;

    // responder state
    logic        hr_drv = 1'b1;
    logic        dp_act = 1'b0, dp_wr = 1'b0, dp_err = 1'b0, dp_estage = 1'b0;
    logic [31:0] dp_addr = '0, dp_wdata = '0;
    int          dp_wait = 0;
    logic        s_nonseq = 1'b0, s_hwrite = 1'b0;
    logic [31:0] s_haddr = '0, s_hwdata = '0;
    logic [2:0]  s_hsize = '0;
    int          run = 0, max_run = 0;

    // driver state
    logic        nxt_valid = 1'b0;
    ahb_req_t    nxt_req;
    int          nxt_waits = 0, nxt_lat = -1;
    logic        accepted = 1'b0;
    int          tries = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] init_word(input logic [31:0] a);
        return a ^ 32'h5A5A_C3C3;
    endfunction

    function automatic logic is_err(input logic [31:0] a);
        return a[31:16] == 16'hFFFF;
    endfunction

    // One clock cycle: responder, response scoreboard, request driver.
    task automatic step();
        aphase_t a;
        rsp_t    r;
        @(negedge clock);
        cyc++;
        if (!hr_drv && s_nonseq) begin
            check_eq("hold_htrans", 32'(htrans), 32'(HTRANS_NONSEQ));
            check_eq("hold_haddr", haddr, s_haddr);
        end
        if (hr_drv) begin
            if (dp_act && dp_wr) begin
                check_eq("hwdata", s_hwdata, dp_wdata);
                if (!dp_err) slv_mem[dp_addr] = s_hwdata;
            end
            dp_act = 1'b0;
            if (s_nonseq) begin
                check_eq("addr_phase_expected", 32'(aq.size() > 0), 32'd1);
                if (aq.size() > 0) begin
                    a = aq.pop_front();
                    check_eq("haddr", s_haddr, a.req.address);
                    check_eq("hwrite", 32'(s_hwrite), 32'(a.req.write));
                    check_eq("hsize", 32'(s_hsize), 32'(a.req.size));
                    dp_act = 1'b1; dp_addr = a.req.address; dp_wr = a.req.write;
                    dp_wdata = a.req.wdata; dp_wait = a.waits;
                    dp_err = is_err(a.req.address); dp_estage = 1'b0;
                end
            end
        end else if (dp_act) begin
            if (dp_err) dp_estage = 1'b1;
            else dp_wait--;
        end
        if (!dp_act) begin
            hready = 1'b1; hresp = 1'b0; hrdata = $urandom;
        end else if (dp_err) begin
            hready = dp_estage; hresp = 1'b1; hrdata = $urandom;
        end else if (dp_wait > 0) begin
            hready = 1'b0; hresp = 1'b0; hrdata = $urandom;
        end else begin
            hready = 1'b1; hresp = 1'b0;
            hrdata = dp_wr ? $urandom : (slv_mem.exists(dp_addr) ? slv_mem[dp_addr] : init_word(dp_addr));
        end
        hr_drv = hready;
        s_nonseq = (htrans == HTRANS_NONSEQ);
        s_haddr = haddr; s_hwrite = hwrite; s_hsize = hsize; s_hwdata = hwdata;
        if (!s_nonseq) check_eq("idle_addr_phase", {haddr[27:0], hsize, hwrite}, 32'd0);
        if (!(dp_act && dp_wr)) check_eq("hwdata_idle", hwdata, 32'd0);
        run = s_nonseq ? run + 1 : 0;
        if (run > max_run) max_run = run;
        if (rsp_valid) begin
            check_eq("rsp_expected", 32'(rq.size() > 0), 32'd1);
            if (rq.size() > 0) begin
                r = rq.pop_front();
                check_eq("rsp_rdata", rsp_rdata, r.rdata);
                check_eq("rsp_error", 32'(rsp_error), 32'(r.err));
                if (r.lat >= 0) check_eq("rsp_latency", 32'(cyc - r.cyc), 32'(r.lat));
            end
        end
        req_valid = nxt_valid;
        if (nxt_valid) begin
            req_write = nxt_req.write; req_size = nxt_req.size;
            req_address = nxt_req.address; req_wdata = nxt_req.wdata;
        end else begin
            req_write = 1'($urandom); req_size = 3'($urandom);
            req_address = $urandom; req_wdata = $urandom;
        end
        #1;
        check_eq("req_ready", 32'(req_ready), 32'(!s_nonseq || hready));
        accepted = req_valid && req_ready;
        if (accepted) begin
            a.req = nxt_req; a.waits = nxt_waits;
            aq.push_back(a);
            r.err = is_err(nxt_req.address);
            if (nxt_req.write || r.err) r.rdata = '0;
            else r.rdata = ref_mem.exists(nxt_req.address) ? ref_mem[nxt_req.address] : init_word(nxt_req.address);
            if (nxt_req.write && !r.err) ref_mem[nxt_req.address] = nxt_req.wdata;
            r.cyc = cyc; r.lat = nxt_lat;
            rq.push_back(r);
        end
    endtask

    task automatic send(input logic w, input logic [2:0] sz, input logic [31:0] ad,
                        input logic [31:0] wd, input int waits, input int lat);
        nxt_valid = 1'b1;
        nxt_req = '{write: w, size: sz, address: ad, wdata: wd};
        nxt_waits = waits; nxt_lat = lat;
        tries = 0;
        do begin
            step();
            tries++;
        end while (!accepted && tries < 200);
        check_eq("req_accept", 32'(accepted), 32'd1);
        nxt_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((rq.size() > 0 || aq.size() > 0 || dp_act) && n < 300) begin
            step();
            n++;
        end
        check_eq("drain_pending_rsp", 32'(rq.size()), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL sim_timeout: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

    initial begin
        hready = 1'b1; hresp = 1'b0; hrdata = '0;
        req_valid = 1'b0; req_write = 1'b0; req_size = '0; req_address = '0; req_wdata = '0;
        nxt_req = '0;

        // reset state
        @(posedge clock); #1;
        check_eq("rst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        check_eq("rst_haddr", haddr, 32'd0);
        check_eq("rst_hsize_hwrite", {28'd0, hsize, hwrite}, 32'd0);
        check_eq("rst_hwdata", hwdata, 32'd0);
        check_eq("rst_rsp", {29'd0, rsp_valid, rsp_error, timeout}, 32'd0);
        check_eq("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("rst_req_ready", 32'(req_ready), 32'd1);
        check_eq("const_hburst", 32'(hburst), 32'(HBURST_SINGLE));
        check_eq("const_hprot", 32'(hprot), 32'h3);
        check_eq("const_hmastlock", 32'(hmastlock), 32'd0);
        @(posedge clock); #1 reset = 1'b0;

        // zero-wait write then read
        send(1'b1, HSIZE_WORD, 32'h100, 32'hDEAD_BEEF, 0, 3);
        check_eq("wr_rd_ready_w", 32'(tries), 32'd1);
        send(1'b0, HSIZE_WORD, 32'h100, 32'h0, 0, 3);
        check_eq("wr_rd_ready_r", 32'(tries), 32'd1);
        drain();

        // back-to-back streaming
        max_run = 0;
        for (int i = 0; i < 4; i++) begin
            send(1'b0, HSIZE_WORD, 32'(i * 4), 32'h0, 0, 3);
            check_eq("stream_ready", 32'(tries), 32'd1);
        end
        drain();
        check_eq("stream_nonseq_run", 32'(max_run), 32'd4);

        // wait states on a read data phase
        send(1'b0, HSIZE_WORD, 32'h200, 32'h0, 3, 6);
        send(1'b0, HSIZE_WORD, 32'h204, 32'h0, 0, 6);
        send(1'b0, HSIZE_WORD, 32'h208, 32'h0, 0, 3);
        check_eq("wait_req_ready_low", 32'(tries - 1), 32'd3);
        drain();

        // ERROR response followed by a pipelined read
        send(1'b1, HSIZE_WORD, 32'hFFFF_0000, 32'h1234_5678, 0, 4);
        send(1'b0, HSIZE_WORD, 32'h100, 32'h0, 0, 4);
        drain();
        check_eq("no_timeout_yet", 32'(timeout), 32'd0);

        // watchdog
        send(1'b0, HSIZE_WORD, 32'h300, 32'h0, 12, 15);
        repeat (9) step();
        check_eq("wd_before_8", 32'(timeout), 32'd0);
        step();
        check_eq("wd_set_at_8", 32'(timeout), 32'd1);
        drain();
        check_eq("wd_sticky", 32'(timeout), 32'd1);

        // reset during a stalled data phase
        send(1'b0, HSIZE_WORD, 32'h400, 32'h0, 10, -1);
        send(1'b0, HSIZE_WORD, 32'h404, 32'h0, 0, -1);
        repeat (3) step();
        reset = 1'b1;
        #1;
        check_eq("midrst_htrans", 32'(htrans), 32'(HTRANS_IDLE));
        check_eq("midrst_haddr", haddr, 32'd0);
        check_eq("midrst_timeout", 32'(timeout), 32'd0);
        check_eq("midrst_req_ready", 32'(req_ready), 32'd1);
        aq.delete(); rq.delete();
        dp_act = 1'b0; hr_drv = 1'b1; s_nonseq = 1'b0;
        hready = 1'b1; hresp = 1'b0; req_valid = 1'b0;
        repeat (2) begin
            @(negedge clock);
            check_eq("midrst_rsp_valid", 32'(rsp_valid), 32'd0);
        end
        @(posedge clock); #1 reset = 1'b0;
        send(1'b0, HSIZE_WORD, 32'h100, 32'h0, 0, 3);
        drain();

        // randomized traffic
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                step();
            end else begin
                logic [31:0] ad;
                ad = ($urandom_range(0, 15) == 0) ? (32'hFFFF_0000 + 32'($urandom_range(0, 3)) * 4)
                                                  : 32'($urandom_range(0, 15)) * 4;
                send(1'($urandom), 3'($urandom_range(0, 2)), ad, $urandom, $urandom_range(0, 3), -1);
            end
        end
        drain();
        check_eq("rand_no_timeout", 32'(timeout), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tb_ahb_master.md
# tb_ahb_master

Testbench AHB-Lite initiator that converts a simple valid/ready request stream into single (non-burst) AHB-Lite transfers and returns one response per request. It sits between a testbench stimulus driver and any AHB-Lite responder, including the team's AHB RAM models. It keeps at most one address phase and one data phase in flight, pipelined per the AHB-Lite rules, and includes a stall watchdog.

## Interface

Parameters:
- `HPROT`, default 4'b0011: constant driven on `hprot`.
- `TIMEOUT_CYCLES`, default 1024: consecutive `hready`-low cycles that set `timeout`.

Ports. One clock; reset is asynchronous and active-high.
- `clock`, in, 1: sole clock, rising edge.
- `reset`, in, 1: asynchronous, active-high.
- `req_valid`, in, 1: request present.
- `req_ready`, out, 1: request accepted this cycle when high together with `req_valid`.
- `req_write`, in, 1: 1 = write, 0 = read.
- `req_size`, in, 3: HSIZE encoding; only 0 to 2 are legal.
- `req_address`, in, 32: byte address.
- `req_wdata`, in, 32: write data, already lane-positioned.
- `rsp_valid`, out, 1: one-cycle pulse per completed transfer.
- `rsp_rdata`, out, 32: read data; 0 for writes.
- `rsp_error`, out, 1: transfer ended with an ERROR response.
- `timeout`, out, 1: sticky watchdog flag.
- `htrans`, `hsize`, `hburst`, `hprot`, `hmastlock`, `hwrite`, `haddr`, `hwdata`: out; widths 2, 3, 3, 4, 1, 1, 32, 32. These are the AHB-Lite master outputs.
- `hrdata`, in, 32; `hready`, in, 1; `hresp`, in, 1: AHB-Lite responder inputs.

## Operation

- Address-phase register A holds `a_valid`, `a_write`, `a_size`, `a_addr`, `a_wdata`.
  - `htrans` = NONSEQ (2'b10) when `a_valid`, otherwise IDLE (2'b00).
  - `haddr`, `hsize` and `hwrite` come from A. When `a_valid` = 0 they are 0.
- Data-phase register D holds `d_valid`, `d_write`, `d_wdata`.
  - `hwdata` = `d_wdata` when `d_valid && d_write`, otherwise 0.
- Constant outputs: `hburst` = 3'b000 (SINGLE), `hmastlock` = 0, `hprot` = `HPROT`.
- `req_ready` = `!a_valid || hready`. This is combinational from `hready`.
- On each rising edge with `hready` = 1:
  - D loads from A: `d_valid` <= `a_valid`.
  - A loads the request if `req_valid && req_ready`; otherwise `a_valid` <= 0.
- On each rising edge with `hready` = 0:
  - A and D hold. The address phase stays stable.
  - A request can be accepted only if `a_valid` = 0. In that case A loads it, which makes the address phase valid with no wait.
- Completion happens on an edge where `d_valid && hready`. On the next cycle:
  - `rsp_valid` = 1.
  - `rsp_error` = `hresp`.
  - `rsp_rdata` = `hrdata` for reads, 0 for writes.
- ERROR response (`hresp` = 1, `hready` = 0, then `hresp` = 1, `hready` = 1):
  - The pending address phase is not cancelled.
  - The response is reported once, at the second cycle.
  - `rsp_error` = 1 and `rsp_rdata` = 0.
- `req_size` > 2 and misaligned addresses are forwarded unchanged. Checking them is the responder's job.
- Watchdog:
  - A 32-bit saturating counter increments each cycle that `hready` = 0 and (`a_valid` or `d_valid`).
  - It clears on any cycle with `hready` = 1.
  - When it reaches `TIMEOUT_CYCLES`, `timeout` sets and stays set until reset.
- No response backpressure: the requester must always accept `rsp_valid`.

## Timing

- Reset values: `htrans` = IDLE; `haddr`, `hsize`, `hwrite`, `hwdata` = 0; `rsp_valid`, `rsp_error`, `timeout` = 0; `rsp_rdata` = 0; `a_valid`, `d_valid` = 0; watchdog count = 0.
- Reset asserted mid-transfer drops both phases. No response is issued for them, and `htrans` is IDLE immediately on assertion.
- Zero-wait latency for a request accepted at edge N:
  - Cycle N+1: address phase.
  - Cycle N+2: data phase.
  - Cycle N+3: `rsp_valid`.
- Throughput is 1 transfer per cycle when `hready` stays high.
- Each wait state adds 1 cycle. Responses are returned in request order.
- `req_valid` is allowed in the same cycle as `reset` deassertion. It is accepted at the first edge after deassertion.

## Structure

- Package `tb_ahb_pkg` holds:
  - HTRANS_IDLE / BUSY / NONSEQ / SEQ;
  - HBURST_SINGLE;
  - HSIZE_BYTE / HALF / WORD;
  - struct `ahb_req_t` (write, size, address, wdata).
- One natural sub-module, `tb_ahb_watchdog`: the saturating stall counter and the sticky flag, parameterised by `TIMEOUT_CYCLES`.
- Everything else (the A/D pipeline registers and response register) is in the top module.

## Test plan

- Zero-wait write-then-read: write 0xDEADBEEF to 0x100 (size 2), then read 0x100. Expect two responses on consecutive cycles with `rsp_error` = 0; the read returns `rsp_rdata` = 0xDEADBEEF.
- Back-to-back streaming: four reads to 0x0, 0x4, 0x8, 0xC with `req_valid` held high. Expect `req_ready` = 1 every cycle, `htrans` = NONSEQ for 4 consecutive cycles, and 4 in-order `rsp_valid` pulses.
- Wait states: the responder holds `hready` = 0 for 3 cycles during a read data phase. Expect `haddr` and `htrans` of the next request held stable, `req_ready` = 0, and the response 3 cycles later than zero-wait.
- Error response: two-cycle ERROR on a write to 0xFFFF0000. Expect exactly one `rsp_valid` with `rsp_error` = 1, and the following pipelined request still completes normally.
- Watchdog: `TIMEOUT_CYCLES` = 8 and `hready` stuck at 0 during a data phase. Expect `timeout` set after 8 stall cycles and still set after `hready` returns.
- Reset mid-transfer: assert `reset` during a stalled data phase. Expect `htrans` = IDLE immediately, no `rsp_valid`, and a clean new transfer after deassertion.
